rv32v_hazard_ctrl: RTL and testbench
====================================

# rv32v_hazard_ctrl

Pipeline hazard controller for the RV32V vector pipeline. It consumes the busy/enable/event signals driven by the fetch1, fetch2, decode, execute, memory and writeback stages and produces per-stage stall and flush controls. It handles three cases: back-pressure stalls with bubble insertion, the flush and drain sequence after a vector CSR update (vsetvl/vsetvli), and the flush and hold sequence after a memory-stage exception. It also keeps a performance counter of decode-stall cycles.

## Interface
Parameters:
- EXC_HOLD_CYCLES, 2: cycles fetch1 stays stalled after an exception flush while the trap redirect settles. Legal range is 1..15.
- CNT_W, 32: width of the stall performance counter.

Ports:
- CLK  in  1  clock. Everything is rising-edge.
- RST  in  1  synchronous, active-high reset.
- busy_f1, busy_f2, busy_dec, busy_ex, busy_mem  in  1 each  stage cannot advance this cycle.
- v_busy  in  1  decode vector-expansion latch is holding the current instruction.
- csr_update  in  1  memory stage holds a vector CSR write (vl/vtype change).
- exception_mem  in  1  memory stage raised an exception.
- writeback_ena  in  1  an instruction retires this cycle.
- stall_f1, stall_f2, stall_dec, stall_ex, stall_mem  out  1 each  hold the stage register.
- flush_f1, flush_f2, flush_dec, flush_ex, flush_mem  out  1 each  clear the stage register (insert a bubble).
- v_stall_cnt  out  CNT_W  count of cycles in which stall_dec=1.

## Operation
- Outputs are combinational from the current state and the current-cycle inputs.
- Registered state:
  - FSM state {RUN, CSR_WAIT, EXC_HOLD}
  - hold counter, 4 bits
  - v_stall_cnt
- Back-pressure, computed in every state before any overrides:
  - stall_mem = busy_mem
  - stall_ex = busy_ex | stall_mem
  - stall_dec = busy_dec | v_busy | stall_ex
  - stall_f2 = busy_f2 | stall_dec
  - stall_f1 = busy_f1 | stall_f2
- Bubble insertion: flush_ex = stall_dec & !stall_ex, and flush_mem = stall_ex & !stall_mem.
- RUN with exception_mem=1 (highest priority):
  - Assert all five flushes.
  - Force all stalls to 0.
  - Load hold counter = EXC_HOLD_CYCLES.
  - Next state is EXC_HOLD.
- RUN with csr_update=1 and exception_mem=0:
  - Assert flush_f1, flush_f2, flush_dec, flush_ex and force their stalls to 0.
  - The memory stage keeps back-pressure behaviour so the CSR op completes.
  - Next state is CSR_WAIT.
- CSR_WAIT:
  - Force stall_f1=1. Other stages follow back-pressure.
  - On writeback_ena=1, return to RUN.
  - exception_mem=1 takes priority over both: perform the exception flush and go to EXC_HOLD.
  - csr_update is ignored.
- EXC_HOLD:
  - Force stall_f1=1. Other stages follow back-pressure.
  - Decrement the hold counter every cycle. When it reaches 1, return to RUN on the next edge.
  - A new exception_mem=1 re-performs the flush and reloads the counter.
  - csr_update is ignored.
- Flush on a stage overrides stall on the same stage; a stage never sees both asserted.
- v_stall_cnt increments each cycle in which stall_dec=1. It wraps modulo 2^CNT_W with no saturation.

## Timing
- Reset:
  - While RST=1, every stall_* and flush_* output is 0.
  - State becomes RUN, hold counter 0, v_stall_cnt 0.
  - Reset asserted mid-sequence (in CSR_WAIT or EXC_HOLD) abandons the sequence; the block is in RUN at the first cycle after RST deasserts.
- Latency:
  - Back-pressure and bubble responses are zero-cycle (same cycle as the busy input).
  - The event flush occurs in the same cycle as csr_update or exception_mem.
- Exception hold: stall_f1 is forced high for exactly EXC_HOLD_CYCLES cycles after the flush cycle. There is no overlap with the flush cycle.
- CSR wait: stall_f1 stays high from the cycle after the flush up to and including the cycle in which writeback_ena=1 is seen. RUN resumes the following cycle. writeback_ena in the flush cycle itself is not counted.
- Simultaneous events:
  - exception_mem together with csr_update: exception path only.
  - busy_* together with an event: flushes win for the flushed stages.
- v_stall_cnt updates on the edge following the stalled cycle.

## Test plan
- Back-pressure: busy_ex=1 for 3 cycles, all else 0 -> stall_ex/dec/f2/f1=1 and flush_mem=1 in each of those cycles; stall_mem=0; v_stall_cnt reaches 3.
- Decode expansion: v_busy=1 for 2 cycles -> stall_dec/f2/f1=1 and flush_ex=1 in each; stall_ex=0; flush_mem=0.
- CSR update: csr_update=1 at cycle N, writeback_ena=1 at N+3 -> flush_f1..flush_ex=1 and flush_mem=0 at N; stall_f1=1 over N+1..N+3; state RUN and stall_f1=0 at N+4.
- Exception, EXC_HOLD_CYCLES=2: exception_mem=1 at N -> all flushes=1 and all stalls=0 at N; stall_f1=1 at N+1 and N+2; stall_f1=0 at N+3.
- Priority and pre-emption: csr_update=1 with exception_mem=1 at N -> all five flushes at N and EXC_HOLD entered. Separately, exception_mem=1 during CSR_WAIT -> exception flush, counter loaded, CSR_WAIT abandoned.
- Reset mid-sequence: RST=1 at N+1 after an exception at N -> outputs 0 while RST=1; after release, stall_f1=0 and v_stall_cnt=0. Counter wrap with CNT_W=4: 17 stalled cycles -> v_stall_cnt=1.

Source files
------------

// File: rtl/rv32v_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// rv32v_hazard_ctrl
//
// Pipeline hazard controller for the RV32V vector pipeline. Turns per-stage
// busy signals and memory-stage events into per-stage stall/flush controls:
//   - back-pressure stalls with bubble insertion between a stalled and a
//     moving stage,
//   - flush + drain after a vector CSR update (wait for its retirement),
//   - flush + fetch hold after a memory-stage exception (trap redirect).
// Also counts the cycles in which decode is stalled.
//
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   busy_f1 .. busy_mem            stage cannot advance this cycle
//   v_busy                         decode vector-expansion latch holding
//   csr_update                     vector CSR write sitting in memory stage
//   exception_mem                  memory stage raised an exception
//   writeback_ena                  an instruction retires this cycle
//   stall_f1 .. stall_mem          hold the stage register
//   flush_f1 .. flush_mem          clear the stage register (bubble)
//   v_stall_cnt                    cycles with stall_dec=1 (wraps)
//
// Outputs are combinational from the current state and current inputs.
// -----------------------------------------------------------------------------
module rv32v_hazard_ctrl #(
  parameter int EXC_HOLD_CYCLES = 2,
  parameter int CNT_W           = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             busy_f1,
  input  logic             busy_f2,
  input  logic             busy_dec,
  input  logic             busy_ex,
  input  logic             busy_mem,
  input  logic             v_busy,
  input  logic             csr_update,
  input  logic             exception_mem,
  input  logic             writeback_ena,
  output logic             stall_f1,
  output logic             stall_f2,
  output logic             stall_dec,
  output logic             stall_ex,
  output logic             stall_mem,
  output logic             flush_f1,
  output logic             flush_f2,
  output logic             flush_dec,
  output logic             flush_ex,
  output logic             flush_mem,
  output logic [CNT_W-1:0] v_stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    CSR_WAIT = 2'd1,
    EXC_HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       hold_q, hold_d;
  logic [CNT_W-1:0] v_stall_cnt_q, v_stall_cnt_d;

  // back-pressure chain before any event overrides
  logic bp_f1, bp_f2, bp_dec, bp_ex, bp_mem;
  logic bp_flush_ex, bp_flush_mem;

  // pre-reset-gating stall/flush values
  logic st_f1, st_f2, st_dec, st_ex, st_mem;
  logic fl_f1, fl_f2, fl_dec, fl_ex, fl_mem;

  // Next-state, hold counter and stall/flush decode.
  always_comb begin
    // A stage stalls when it is busy or anything downstream holds it.
    bp_mem       = busy_mem;
    bp_ex        = busy_ex | bp_mem;
    bp_dec       = busy_dec | v_busy | bp_ex;
    bp_f2        = busy_f2 | bp_dec;
    bp_f1        = busy_f1 | bp_f2;
    // Bubble into the first stage that moves while the one above it holds.
    bp_flush_ex  = bp_dec & ~bp_ex;
    bp_flush_mem = bp_ex & ~bp_mem;

    st_f1   = bp_f1;
    st_f2   = bp_f2;
    st_dec  = bp_dec;
    st_ex   = bp_ex;
    st_mem  = bp_mem;
    fl_f1   = 1'b0;
    fl_f2   = 1'b0;
    fl_dec  = 1'b0;
    fl_ex   = bp_flush_ex;
    fl_mem  = bp_flush_mem;
    state_d = state_q;
    hold_d  = hold_q;

    // An exception beats every other event in every state: flush all five
    // stages, drop all stalls and (re)arm the fetch hold.
    if (exception_mem) begin
      st_f1   = 1'b0;
      st_f2   = 1'b0;
      st_dec  = 1'b0;
      st_ex   = 1'b0;
      st_mem  = 1'b0;
      fl_f1   = 1'b1;
      fl_f2   = 1'b1;
      fl_dec  = 1'b1;
      fl_ex   = 1'b1;
      fl_mem  = 1'b1;
      hold_d  = 4'(EXC_HOLD_CYCLES);
      state_d = EXC_HOLD;
    end else begin
      case (state_q)
        RUN: begin
          if (csr_update) begin
            // Memory stage keeps its back-pressure so the CSR op completes.
            st_f1   = 1'b0;
            st_f2   = 1'b0;
            st_dec  = 1'b0;
            st_ex   = 1'b0;
            fl_f1   = 1'b1;
            fl_f2   = 1'b1;
            fl_dec  = 1'b1;
            fl_ex   = 1'b1;
            state_d = CSR_WAIT;
          end else begin
            state_d = RUN;
          end
        end
        CSR_WAIT: begin
          // Fetch is held until the CSR instruction retires.
          st_f1 = 1'b1;
          if (writeback_ena) begin
            state_d = RUN;
          end else begin
            state_d = CSR_WAIT;
          end
        end
        EXC_HOLD: begin
          st_f1  = 1'b1;
          hold_d = hold_q - 4'd1;
          if (hold_q <= 4'd1) begin
            state_d = RUN;
          end else begin
            state_d = EXC_HOLD;
          end
        end
        default: begin
          state_d = RUN;
          hold_d  = 4'd0;
        end
      endcase
    end
  end

  // Outputs are quiet while reset is held.
  assign stall_f1  = st_f1  & ~RST;
  assign stall_f2  = st_f2  & ~RST;
  assign stall_dec = st_dec & ~RST;
  assign stall_ex  = st_ex  & ~RST;
  assign stall_mem = st_mem & ~RST;
  assign flush_f1  = fl_f1  & ~RST;
  assign flush_f2  = fl_f2  & ~RST;
  assign flush_dec = fl_dec & ~RST;
  assign flush_ex  = fl_ex  & ~RST;
  assign flush_mem = fl_mem & ~RST;

  // Decode-stall performance counter, wraps without saturation.
  always_comb begin
    v_stall_cnt_d = v_stall_cnt_q + CNT_W'(stall_dec);
  end

  assign v_stall_cnt = v_stall_cnt_q;

  // State, hold counter and performance counter registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= RUN;
      hold_q        <= 4'd0;
      v_stall_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      v_stall_cnt_q <= v_stall_cnt_d;
    end
  end

endmodule

// File: tb/tb_rv32v_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_rv32v_hazard_ctrl
//
// Scoreboard bench: each driven cycle pushes its expected stall/flush vectors
// and expected counter value; a negedge monitor pops and compares them.
// DUT built with EXC_HOLD_CYCLES=2 and CNT_W=4 so the counter wraps.
// Vector order for stalls/flushes: {f1, f2, dec, ex, mem}.
// -----------------------------------------------------------------------------
module tb_rv32v_hazard_ctrl;

  localparam int HOLD = 2;
  localparam int CW   = 4;

  // Input vector order: {RST, bf1, bf2, bdec, bex, bmem, vb, csr, exc, wb}
  localparam logic [9:0] I_IDLE = 10'b0000000000;
  localparam logic [9:0] I_RST  = 10'b1000000000;
  localparam logic [9:0] I_BDEC = 10'b0001000000;
  localparam logic [9:0] I_BEX  = 10'b0000100000;
  localparam logic [9:0] I_BMEM = 10'b0000010000;
  localparam logic [9:0] I_VB   = 10'b0000001000;
  localparam logic [9:0] I_CSR  = 10'b0000000100;
  localparam logic [9:0] I_EXC  = 10'b0000000010;
  localparam logic [9:0] I_WB   = 10'b0000000001;

  logic clk = 1'b0;
  logic rst, busy_f1, busy_f2, busy_dec, busy_ex, busy_mem;
  logic v_busy, csr_update, exception_mem, writeback_ena;
  logic stall_f1, stall_f2, stall_dec, stall_ex, stall_mem;
  logic flush_f1, flush_f2, flush_dec, flush_ex, flush_mem;
  logic [CW-1:0] v_stall_cnt;

  typedef struct {
    string      tag;
    logic [4:0] es;
    logic [4:0] ef;
    logic [3:0] cnt;
    bit         chk_cnt;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  logic [3:0] exp_cnt = 4'd0;
  bit         cnt_valid = 1'b0;

  always #5 clk = ~clk;

  rv32v_hazard_ctrl #(
    .EXC_HOLD_CYCLES(HOLD),
    .CNT_W          (CW)
  ) dut (
    .CLK          (clk),
    .RST          (rst),
    .busy_f1      (busy_f1),
    .busy_f2      (busy_f2),
    .busy_dec     (busy_dec),
    .busy_ex      (busy_ex),
    .busy_mem     (busy_mem),
    .v_busy       (v_busy),
    .csr_update   (csr_update),
    .exception_mem(exception_mem),
    .writeback_ena(writeback_ena),
    .stall_f1     (stall_f1),
    .stall_f2     (stall_f2),
    .stall_dec    (stall_dec),
    .stall_ex     (stall_ex),
    .stall_mem    (stall_mem),
    .flush_f1     (flush_f1),
    .flush_f2     (flush_f2),
    .flush_dec    (flush_dec),
    .flush_ex     (flush_ex),
    .flush_mem    (flush_mem),
    .v_stall_cnt  (v_stall_cnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the expected response.
  task automatic cyc(input string tag, input logic [9:0] in_v,
                     input logic [4:0] es, input logic [4:0] ef);
    exp_t e;
    @(posedge clk);
    #1;
    {rst, busy_f1, busy_f2, busy_dec, busy_ex, busy_mem,
     v_busy, csr_update, exception_mem, writeback_ena} = in_v;
    e.tag     = tag;
    e.es      = es;
    e.ef      = ef;
    e.cnt     = exp_cnt;
    e.chk_cnt = cnt_valid;
    sb.push_back(e);
    if (in_v[9]) begin
      exp_cnt   = 4'd0;
      cnt_valid = 1'b1;
    end else begin
      exp_cnt = exp_cnt + {3'b000, es[2]};
    end
  endtask

  // Monitor: compare outputs mid-cycle against the oldest expectation.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check_eq({e.tag, "_stall"}, 32'({stall_f1, stall_f2, stall_dec, stall_ex, stall_mem}), 32'(e.es));
      check_eq({e.tag, "_flush"}, 32'({flush_f1, flush_f2, flush_dec, flush_ex, flush_mem}), 32'(e.ef));
      if (e.chk_cnt) check_eq({e.tag, "_cnt"}, 32'(v_stall_cnt), 32'(e.cnt));
    end
  end

  initial begin
    {rst, busy_f1, busy_f2, busy_dec, busy_ex, busy_mem,
     v_busy, csr_update, exception_mem, writeback_ena} = 10'b1000000000;

    cyc("reset0", I_RST, 5'b00000, 5'b00000);
    cyc("reset1", I_RST, 5'b00000, 5'b00000);
    cyc("idle",   I_IDLE, 5'b00000, 5'b00000);

    // busy_ex: ex and everything upstream stall, bubble into mem
    for (int i = 0; i < 3; i++) cyc("bp_ex", I_BEX, 5'b11110, 5'b00001);
    cyc("bp_ex_done", I_IDLE, 5'b00000, 5'b00000);

    // vector expansion: decode holds, bubble into ex
    for (int i = 0; i < 2; i++) cyc("vbusy", I_VB, 5'b11100, 5'b00010);
    cyc("vbusy_done", I_IDLE, 5'b00000, 5'b00000);

    // CSR update, retirement three cycles later, mem back-pressure in between
    cyc("csr_n",    I_CSR,  5'b00000, 5'b11110);
    cyc("csr_n1",   I_IDLE, 5'b10000, 5'b00000);
    cyc("csr_bmem", I_BMEM, 5'b11111, 5'b00000);
    cyc("csr_wb",   I_WB,   5'b10000, 5'b00000);
    cyc("csr_run",  I_IDLE, 5'b00000, 5'b00000);

    // writeback in the flush cycle itself does not end the wait
    cyc("csrwb_n",   I_CSR | I_WB, 5'b00000, 5'b11110);
    cyc("csrwb_n1",  I_IDLE,       5'b10000, 5'b00000);
    cyc("csrwb_wb",  I_WB,         5'b10000, 5'b00000);
    cyc("csrwb_run", I_IDLE,       5'b00000, 5'b00000);

    // exception with busy_ex: flush wins, then two hold cycles
    cyc("exc_n",   I_EXC | I_BEX, 5'b00000, 5'b11111);
    cyc("exc_h1",  I_IDLE,        5'b10000, 5'b00000);
    cyc("exc_h2",  I_IDLE,        5'b10000, 5'b00000);
    cyc("exc_run", I_IDLE,        5'b00000, 5'b00000);

    // second exception during the hold reloads the counter
    cyc("rexc_n",   I_EXC,  5'b00000, 5'b11111);
    cyc("rexc_re",  I_EXC,  5'b00000, 5'b11111);
    cyc("rexc_h1",  I_IDLE, 5'b10000, 5'b00000);
    cyc("rexc_h2",  I_IDLE, 5'b10000, 5'b00000);
    cyc("rexc_run", I_IDLE, 5'b00000, 5'b00000);

    // csr + exception together: exception path only (ends without writeback)
    cyc("both_n",   I_CSR | I_EXC, 5'b00000, 5'b11111);
    cyc("both_h1",  I_IDLE,        5'b10000, 5'b00000);
    cyc("both_h2",  I_IDLE,        5'b10000, 5'b00000);
    cyc("both_run", I_IDLE,        5'b00000, 5'b00000);

    // exception pre-empts CSR_WAIT
    cyc("pre_csr",  I_CSR,  5'b00000, 5'b11110);
    cyc("pre_w1",   I_IDLE, 5'b10000, 5'b00000);
    cyc("pre_exc",  I_EXC,  5'b00000, 5'b11111);
    cyc("pre_h1",   I_IDLE, 5'b10000, 5'b00000);
    cyc("pre_h2",   I_IDLE, 5'b10000, 5'b00000);
    cyc("pre_run",  I_IDLE, 5'b00000, 5'b00000);

    // reset in the middle of an exception hold
    cyc("rmid_exc", I_EXC,          5'b00000, 5'b11111);
    cyc("rmid_r1",  I_RST | I_BDEC, 5'b00000, 5'b00000);
    cyc("rmid_r2",  I_RST,          5'b00000, 5'b00000);
    cyc("rmid_run", I_IDLE,         5'b00000, 5'b00000);

    // 17 decode stalls on a 4-bit counter wrap to 1
    for (int i = 0; i < 17; i++) cyc("wrap", I_BDEC, 5'b11100, 5'b00010);
    cyc("wrap_done", I_IDLE, 5'b00000, 5'b00000);
    cyc("wrap_cnt1", I_IDLE, 5'b00000, 5'b00000);

    @(posedge clk);
    @(posedge clk);
    check_eq("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute bound on run time.
  initial begin
    #100000;
    $display("FAIL timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
